// File: rtl/uartrx_fifo_if.sv
// Consumer-side bus of the buffered UART receiver.
//   master : the reader (I/O interface) - drives rd_en / clear_errors
//   slave  : the receiver FIFO          - drives data, occupancy and sticky flags
// Signals:
//   rd_en          pop head entry (ignored when empty)
//   rd_data        head entry, 8'h00 when empty (first-word-fall-through)
//   empty / full   occupancy flags
//   count          stored entries (0 .. 2^DepthBitWidth)
//   overrun        sticky: byte dropped because FIFO was full
//   framing_error  sticky: stop bit sampled low
//   clear_errors   clears both sticky flags
interface uartrx_fifo_if #(
  parameter int unsigned DepthBitWidth = 4
);
  logic                   rd_en;
  logic                   clear_errors;
  logic [7:0]             rd_data;
  logic                   empty;
  logic                   full;
  logic [DepthBitWidth:0] count;
  logic                   overrun;
  logic                   framing_error;

  modport master (
    output rd_en, clear_errors,
    input  rd_data, empty, full, count, overrun, framing_error
  );

  modport slave (
    input  rd_en, clear_errors,
    output rd_data, empty, full, count, overrun, framing_error
  );
endinterface

// File: rtl/uartrx_fifo.sv
// Buffered 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   rx     serial line (idle high), asynchronous to clk
//   bus    uartrx_fifo_if.slave : rd_en, rd_data, empty, full, count,
//          overrun, framing_error, clear_errors
module uartrx_fifo #(
  parameter int unsigned ClockFrequencyHz = 20_250_000,
  parameter int unsigned BaudRate         = 9600,
  parameter int unsigned DepthBitWidth    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  uartrx_fifo_if.slave   bus
);

  localparam int unsigned BitTime = ClockFrequencyHz / BaudRate;
  localparam int unsigned CntW    = $clog2(BitTime);
  localparam int unsigned Depth   = 1 << DepthBitWidth;

  localparam logic [CntW-1:0]        HalfLoad  = CntW'(BitTime / 2 - 1);
  localparam logic [CntW-1:0]        FullLoad  = CntW'(BitTime - 1);
  localparam logic [DepthBitWidth:0] CountFull = (DepthBitWidth + 1)'(Depth);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------- sync
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------- receiver
  state_t          state;
  logic [CntW-1:0] bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state   <= START;
            bit_cnt <= HalfLoad;
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            if (!rx_sync) begin
              state   <= DATA;
              bit_cnt <= FullLoad;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            shreg[bit_idx] <= rx_sync;
            bit_cnt        <= FullLoad;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == '0) state <= IDLE;
          else               bit_cnt <= bit_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stop-bit sample instant, decoded from state so the push lands in the
  // same cycle the FSM returns to IDLE.
  logic stop_done;
  logic push_req;
  logic frame_bad;

  assign stop_done = (state == STOP) && (bit_cnt == '0);
  assign push_req  = stop_done && rx_sync;
  assign frame_bad = stop_done && !rx_sync;

  // ---------------------------------------------------------------- fifo
  logic [7:0]               mem [Depth];
  logic [DepthBitWidth-1:0] wr_ptr;
  logic [DepthBitWidth-1:0] rd_ptr;
  logic [DepthBitWidth:0]   count_q;
  logic                     overrun_q;
  logic                     ferr_q;
  logic                     is_empty;
  logic                     is_full;
  logic                     do_pop;
  logic                     do_push;
  logic                     drop;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CountFull);
  assign do_pop   = bus.rd_en && !is_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_push  = push_req && (!is_full || do_pop);
  assign drop     = push_req && is_full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Event after clear: a coincident error leaves the flag set.
      if (bus.clear_errors) begin
        overrun_q <= 1'b0;
        ferr_q    <= 1'b0;
      end
      if (drop)      overrun_q <= 1'b1;
      if (frame_bad) ferr_q    <= 1'b1;
    end
  end

  assign bus.rd_data       = is_empty ? 8'h00 : mem[rd_ptr];
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.count         = count_q;
  assign bus.overrun       = overrun_q;
  assign bus.framing_error = ferr_q;

endmodule

// File: tb/tb_uartrx_fifo.sv
module tb_uartrx_fifo;

  localparam int BT    = 16;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  logic rx;

  uartrx_fifo_if #(.DepthBitWidth(4)) bus ();

  uartrx_fifo #(
    .ClockFrequencyHz(16),
    .BaudRate        (1),
    .DepthBitWidth   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an ordered queue of received bytes plus two flags.
  logic [7:0] q[$];
  logic       m_ovr;
  logic       m_fe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    check({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    check({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    check({tag, ".full"},  32'(bus.full),  32'(q.size() == DEPTH));
    check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(head));
    check({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
    check({tag, ".ferr"}, 32'(bus.framing_error), 32'(m_fe));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model outcome of one received frame; pop_same is a coincident rd_en.
  task automatic model_frame(input logic [7:0] d, input logic stop, input bit pop_same);
    if (pop_same && q.size() != 0) void'(q.pop_front());
    if (!stop)                   m_fe = 1'b1;
    else if (q.size() < DEPTH)   q.push_back(d);
    else                         m_ovr = 1'b1;
  endtask

  // Drives ncyc cycles of an 8N1 frame; rd_en high during cycle pop_cycle.
  // The stop bit is sampled 154 cycles after the start edge is driven.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int pop_cycle, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int b;
      b = c / BT;
      if (b == 0)      rx = 1'b0;
      else if (b <= 8) rx = d[b-1];
      else             rx = stop;
      bus.rd_en = (c == pop_cycle);
      tick();
    end
    bus.rd_en = 1'b0;
    rx = 1'b1;
    if (ncyc >= 10 * BT) begin
      for (int c = 0; c < BT; c++) tick();
    end
  endtask

  task automatic recv(input logic [7:0] d, input logic stop, input string tag);
    send_frame(d, stop, -1, 10 * BT);
    model_frame(d, stop, 1'b0);
    check_state(tag);
  endtask

  task automatic pop(input string tag);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_state(tag);
  endtask

  task automatic clear_err(input string tag);
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst_n            = 1'b0;
    rx               = 1'b1;
    bus.rd_en        = 1'b0;
    bus.clear_errors = 1'b0;
    m_ovr            = 1'b0;
    m_fe             = 1'b0;
    repeat (3) tick();
    check_state("reset");
    rst_n = 1'b1;
    repeat (3) tick();

    // single byte, then pop back to empty
    recv(8'h41, 1'b1, "single");
    pop("single_pop");

    // fill, overrun, drain in order
    for (int i = 0; i < DEPTH; i++) recv(8'(i), 1'b1, "fill");
    recv(8'hAA, 1'b1, "overrun");
    for (int i = 0; i < DEPTH; i++) pop("drain");
    clear_err("clr_ovr");

    // full FIFO with pop coincident with the stop-bit push
    for (int i = 0; i < DEPTH; i++) recv(8'($urandom_range(255)), 1'b1, "fill2");
    send_frame(8'h55, 1'b1, 154, 10 * BT);
    model_frame(8'h55, 1'b1, 1'b1);
    check_state("push_pop_full");
    for (int i = 0; i < DEPTH; i++) pop("drain2");

    // short glitch on idle line
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (30) tick();
    check_state("glitch");

    // framing error and clear
    recv(8'h3C, 1'b0, "ferr");
    clear_err("clr_fe");

    // reset in the middle of a frame
    recv(8'h11, 1'b1, "pre_rst");
    recv(8'h22, 1'b1, "pre_rst");
    recv(8'h33, 1'b1, "pre_rst");
    send_frame(8'h99, 1'b1, -1, 5 * BT + 8);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    check_state("mid_rst");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    recv(8'h7E, 1'b1, "after_rst");
    pop("after_rst_pop");

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      logic [7:0] d;
      logic       s;
      int         npop;
      d    = 8'($urandom_range(255));
      s    = ($urandom_range(7) != 0);
      npop = $urandom_range(2);
      recv(d, s, "rand_rx");
      for (int k = 0; k < npop; k++) pop("rand_pop");
      if ($urandom_range(5) == 0) clear_err("rand_clr");
    end
    while (q.size() != 0) pop("final_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uartrx_fifo.md
Name: uartrx_fifo

Overview:
- Buffered UART receiver: serial line in, first-word-fall-through byte FIFO out.
- Sits between the board rx pin and the memory-mapped I/O interface, replacing the single-byte receive latch so back-to-back characters are not overrun while the core is busy on cache/SDRAM stalls.
- The I/O interface pops one byte per read of the UART-in address; empty reads return -1 at that layer.

Parameters:
ClockFrequencyHz, 20_250_000, system clock frequency
BaudRate, 9600, serial bit rate; BitTime = ClockFrequencyHz / BaudRate (integer division, must be >= 4)
DepthBitWidth, 4, FIFO depth = 2^DepthBitWidth entries

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
rx  input  1  UART serial line, idle high, 8N1, asynchronous to clk
rd_en  input  1  pop head entry this cycle; ignored when empty
rd_data  output  8  head entry (valid when !empty); 8'h00 when empty
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds 2^DepthBitWidth entries
count  output  DepthBitWidth+1  number of stored entries
overrun  output  1  sticky: a received byte was dropped because FIFO full
framing_error  output  1  sticky: stop bit sampled low
clear_errors  input  1  clears both sticky flags

Behaviour:
- Reset (async assert, sync-style deassert with clk): empty=1, full=0, count=0, rd_data=0, overrun=0, framing_error=0, FSM=Idle, synchronizer flops=1, read/write pointers=0.
- rx passes a 2-flop synchronizer before use; all rx references below are the synchronized value (2-cycle latency).
- Receiver FSM, one down-counter bit_cnt and 3-bit bit_idx:
  - Idle: on synced rx==0, go to Start, load counter = BitTime/2 - 1.
  - Start: counter reaches 0 -> if rx==0 go to Data, load BitTime-1, bit_idx=0; else go to Idle (glitch, nothing recorded).
  - Data: counter reaches 0 -> shift rx into bit position bit_idx (LSB first), reload BitTime-1; after bit_idx==7 go to Stop.
  - Stop: counter reaches 0 -> if rx==1 push byte; else set framing_error, discard byte. Always return to Idle same cycle.
- Push: writes byte at write pointer; if full and no pop in the same cycle, byte dropped, overrun set, FIFO unchanged.
- Pop: rd_en && !empty advances read pointer; rd_data shows the next entry the following cycle (first-word-fall-through, registered memory read not allowed to add latency).
- Simultaneous push and pop: both performed, count unchanged; when full, the push is accepted because the pop frees a slot (no overrun).
- Simultaneous push and pop when empty: push only (pop ignored); byte visible on rd_data next cycle.
- Pointers wrap modulo 2^DepthBitWidth; count = pushes - pops, never exceeds 2^DepthBitWidth.
- Sticky flags: clear_errors clears; if an error event coincides with clear_errors, the flag ends set.
- Reset asserted mid-frame: partial byte discarded, FSM returns to Idle, FIFO emptied.
- Byte timing: push occurs ~9.5 BitTimes (+2 synchronizer cycles) after start-bit falling edge.

Test Plan:
- ClockFrequencyHz=16, BaudRate=1 (BitTime=16); send 8'h41 -> after ~154 cycles empty=0, count=1, rd_data=8'h41; pulse rd_en -> next cycle empty=1, rd_data=8'h00.
- Send 16 bytes 8'h00..8'h0F with no reads -> full=1, count=16; send 8'hAA -> overrun=1, count=16; pop all -> 8'h00..8'h0F in order, 8'hAA absent.
- With FIFO full, pulse rd_en in exact cycle of stop-bit push of 8'h55 -> count stays 16, overrun=0, 8'h55 is last entry popped.
- Low pulse of 4 cycles on idle rx -> FSM returns to Idle, count=0, no flags set.
- Send 8'h3C with stop bit driven 0 -> framing_error=1, count unchanged; pulse clear_errors -> framing_error=0 next cycle.
- Assert rst_n=0 at bit 4 of a frame with count=3 -> immediately empty=1, count=0; next full frame 8'h7E received correctly after release.
